// File: rtl/carfield_apb_periph_demux.sv
// carfield_apb_periph_demux: APB responder that decodes the peripheral map and re-issues each transfer downstream
// Ports:
//   clk_i, rst_ni                 clock, asynchronous active-low reset
//   s_p*                          upstream APB3/APB4 responder side (from the AXI-to-APB bridge)
//   m_psel_o                      one-hot downstream select, one bit per slot
//   m_penable_o, m_paddr_o, ...   shared downstream request signals (hold the latched transfer)
//   m_prdata_i/m_pready_i/...     per-slot downstream responses
// Optional (CARFIELD_APB_DEMUX_ERR_LOG_EN): err_clr_i, err_valid_o, err_addr_o, err_timeout_o
//   sticky log of the first decode miss or downstream timeout
module carfield_apb_periph_demux #(
    parameter int unsigned NumPorts        = 9,
    parameter int unsigned AddrWidth       = 32,
    parameter int unsigned DataWidth       = 32,
    parameter int unsigned TimeoutCycles   = 256,
    parameter int unsigned CanEnable       = 1,
    parameter int unsigned StreamerEnable  = 1,
    parameter int unsigned SpaceWireEnable = 1
) (
    input  logic                            clk_i,
    input  logic                            rst_ni,
`ifdef CARFIELD_APB_DEMUX_ERR_LOG_EN
    input  logic                            err_clr_i,
    output logic                            err_valid_o,
    output logic [AddrWidth-1:0]            err_addr_o,
    output logic                            err_timeout_o,
`endif
    input  logic [AddrWidth-1:0]            s_paddr_i,
    input  logic                            s_psel_i,
    input  logic                            s_penable_i,
    input  logic                            s_pwrite_i,
    input  logic [DataWidth-1:0]            s_pwdata_i,
    input  logic [DataWidth/8-1:0]          s_pstrb_i,
    input  logic [2:0]                      s_pprot_i,
    output logic [DataWidth-1:0]            s_prdata_o,
    output logic                            s_pready_o,
    output logic                            s_pslverr_o,
    output logic [NumPorts-1:0]             m_psel_o,
    output logic                            m_penable_o,
    output logic [AddrWidth-1:0]            m_paddr_o,
    output logic                            m_pwrite_o,
    output logic [DataWidth-1:0]            m_pwdata_o,
    output logic [DataWidth/8-1:0]          m_pstrb_o,
    output logic [2:0]                      m_pprot_o,
    input  logic [NumPorts*DataWidth-1:0]   m_prdata_i,
    input  logic [NumPorts-1:0]             m_pready_i,
    input  logic [NumPorts-1:0]             m_pslverr_i
);
    localparam int unsigned IdxWidth = NumPorts > 1 ? $clog2(NumPorts) : 1;
    localparam int unsigned CntWidth = TimeoutCycles > 1 ? $clog2(TimeoutCycles) : 1;
    localparam logic [8:0][31:0] SlotBase = {
        32'h2001_9100, 32'h2001_9000, 32'h2001_1000, 32'h2000_9000, 32'h2000_8000,
        32'h2000_7000, 32'h2000_5000, 32'h2000_4000, 32'h2000_1000};
    localparam logic [8:0][31:0] SlotSize = {
        32'h0000_0F00, 32'h0000_0100, 32'h0000_8000, 32'h0000_8000, 32'h0000_1000,
        32'h0000_1000, 32'h0000_1000, 32'h0000_1000, 32'h0000_1000};
    localparam logic [8:0] SlotEn = {{2{SpaceWireEnable != 0}}, {2{StreamerEnable != 0}}, 4'hF, CanEnable != 0};

    typedef enum logic [1:0] {IDLE, M_SETUP, M_ACCESS, RESP} state_e;

    state_e                state_q, state_d;
    logic [IdxWidth-1:0]   idx_q, dec_idx;
    logic [CntWidth-1:0]   cnt_q;
    logic [DataWidth-1:0]  rdata_q;
    logic                  err_q;
    logic                  dec_hit;
    logic [63:0]           addr_ext;
    logic                  capture;
    logic                  sel_ready;
    logic                  timeout;

    assign capture   = s_psel_i && !s_penable_i;
    assign addr_ext  = 64'(s_paddr_i);
    assign sel_ready = m_pready_i[idx_q];
    assign timeout   = (TimeoutCycles != 0) && (cnt_q == CntWidth'(TimeoutCycles - 1));

    // Ranges never overlap, so at most one slot matches.
    always_comb begin
        dec_hit = 1'b0;
        dec_idx = '0;
        for (int unsigned i = 0; i < 9; i++) begin
            if (i < NumPorts && SlotEn[i] && addr_ext >= 64'(SlotBase[i]) &&
                addr_ext < 64'(SlotBase[i]) + 64'(SlotSize[i])) begin
                dec_hit = 1'b1;
                dec_idx = IdxWidth'(i);
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        m_psel_o    = '0;
        m_penable_o = 1'b0;
        s_pready_o  = 1'b0;
        s_prdata_o  = '0;
        s_pslverr_o = 1'b0;
        case (state_q)
            IDLE:     state_d = capture ? (dec_hit ? M_SETUP : RESP) : IDLE;
            M_SETUP: begin
                m_psel_o = NumPorts'(1) << idx_q;
                state_d  = M_ACCESS;
            end
            M_ACCESS: begin
                m_psel_o    = NumPorts'(1) << idx_q;
                m_penable_o = 1'b1;
                state_d     = (sel_ready || timeout) ? RESP : M_ACCESS;
            end
            default: begin
                s_pready_o  = 1'b1;
                s_prdata_o  = rdata_q;
                s_pslverr_o = err_q;
                state_d     = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            idx_q      <= '0;
            cnt_q      <= '0;
            rdata_q    <= '0;
            err_q      <= 1'b0;
            m_paddr_o  <= '0;
            m_pwrite_o <= 1'b0;
            m_pwdata_o <= '0;
            m_pstrb_o  <= '0;
            m_pprot_o  <= '0;
        end else begin
            if (state_q == IDLE && capture) begin
                idx_q      <= dec_idx;
                rdata_q    <= '0;
                err_q      <= !dec_hit;
                m_paddr_o  <= s_paddr_i;
                m_pwrite_o <= s_pwrite_i;
                m_pwdata_o <= s_pwdata_i;
                m_pstrb_o  <= s_pstrb_i;
                m_pprot_o  <= s_pprot_i;
            end
            if (state_q == M_ACCESS) begin
                cnt_q <= (sel_ready || timeout) ? '0 : cnt_q + 1'b1;
                if (sel_ready) begin
                    rdata_q <= m_prdata_i[idx_q*DataWidth +: DataWidth];
                    err_q   <= m_pslverr_i[idx_q];
                end else if (timeout) begin
                    rdata_q <= '0;
                    err_q   <= 1'b1;
                end
            end
        end
    end

`ifdef CARFIELD_APB_DEMUX_ERR_LOG_EN
    logic miss_ev, to_ev;
    assign miss_ev = state_q == IDLE && capture && !dec_hit;
    assign to_ev   = state_q == M_ACCESS && !sel_ready && timeout;

    // A new error in the clear cycle re-arms the log with that error.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            err_valid_o   <= 1'b0;
            err_addr_o    <= '0;
            err_timeout_o <= 1'b0;
        end else if ((miss_ev || to_ev) && (!err_valid_o || err_clr_i)) begin
            err_valid_o   <= 1'b1;
            err_addr_o    <= miss_ev ? s_paddr_i : m_paddr_o;
            err_timeout_o <= to_ev;
        end else if (err_clr_i) begin
            err_valid_o   <= 1'b0;
            err_addr_o    <= '0;
            err_timeout_o <= 1'b0;
        end
    end
`endif

endmodule
